// File: rtl/ext_pipe_skid.sv
// ext_pipe_skid: registered immediate-extension stage with a 2-entry skid buffer.
// Extends an IMM_WIDTH immediate to OUT_WIDTH in zero, sign, upper or branch-offset mode.
// Optional feature macro: EXT_COUNT_EN enables the 16-bit accepted-transaction counter on ext_cnt.
// Without it, ext_cnt is tied to zero.
module ext_pipe_skid #(
  parameter int IMM_WIDTH = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IMM_WIDTH-1:0] imm,
  input  logic [1:0]           ExtOp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] ext_out,
  output logic [15:0]          ext_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [OUT_WIDTH-1:0]   mainData_q, mainData_d;
  logic [OUT_WIDTH-1:0]   skidData_q, skidData_d;
  logic                   inReady_q, outValid_q;
  logic [OUT_WIDTH-1:0]   extResult;
  logic [OUT_WIDTH-1:0]   signExt;
  logic                   accept;
  logic                   deliver;

  assign accept    = in_valid & inReady_q;
  assign deliver   = outValid_q & out_ready;
  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign ext_out   = mainData_q;

  // Extend the incoming immediate combinationally; only this result is ever stored.
  always_comb begin
    signExt   = {{(OUT_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
    extResult = '0;
    case (ExtOp)
      2'b00:   extResult = {{(OUT_WIDTH-IMM_WIDTH){1'b0}}, imm};
      2'b01:   extResult = signExt;
      2'b10:   extResult = {imm, {(OUT_WIDTH-IMM_WIDTH){1'b0}}};
      2'b11:   extResult = signExt << 2;
      default: extResult = '0;
    endcase
  end

  // Occupancy transitions: main register feeds the output, skid catches an accept made during a stall.
  always_comb begin
    state_d    = state_q;
    mainData_d = mainData_q;
    skidData_d = skidData_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d    = ONE;
            mainData_d = extResult;
          end
        end
        ONE: begin
          if (accept && deliver) begin
            mainData_d = extResult;
          end else if (accept) begin
            state_d    = FULL;
            skidData_d = extResult;
          end else if (deliver) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (deliver) begin
            state_d    = ONE;
            mainData_d = skidData_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Register state, data and the handshake outputs so in_ready never depends on out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      mainData_q <= '0;
      skidData_q <= '0;
      inReady_q  <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mainData_q <= mainData_d;
      skidData_q <= skidData_d;
      inReady_q  <= (state_d != FULL);
      outValid_q <= (state_d != EMPTY);
    end
  end

`ifdef EXT_COUNT_EN
  logic [15:0] extCnt_q;

  // Count accepted transactions; accepts swallowed by a flush are not counted, and the count wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      extCnt_q <= 16'h0000;
    end else if (accept && !flush) begin
      extCnt_q <= extCnt_q + 16'h0001;
    end
  end

  assign ext_cnt = extCnt_q;
`else
  assign ext_cnt = 16'h0000;
`endif

endmodule
